// File: rtl/eth_10g_rx_st_drop_fifo.sv
// Packet-aware RX buffering FIFO for the 10G MAC: never backpressures upstream, and on
// overflow it truncates or drops whole packets so the client always sees SOP..EOP framing.
module eth_10g_rx_st_drop_fifo #(
    parameter int unsigned DATA_W  = 64,
    parameter int unsigned EMPTY_W = 3,
    parameter int unsigned DEPTH   = 64,
    parameter int unsigned CNT_W   = 32,
    localparam int unsigned AW     = $clog2(DEPTH),
    localparam int unsigned LVL_W  = AW + 1
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               in_valid,
    input  logic [DATA_W-1:0]  in_data,
    input  logic               in_error,
    input  logic               in_startofpacket,
    input  logic               in_endofpacket,
    input  logic [EMPTY_W-1:0] in_empty,
    output logic               out_valid,
    output logic [DATA_W-1:0]  out_data,
    output logic               out_error,
    output logic               out_startofpacket,
    output logic               out_endofpacket,
    output logic [EMPTY_W-1:0] out_empty,
    input  logic               out_ready,
    output logic [LVL_W-1:0]   fifo_level,
    output logic [CNT_W-1:0]   drop_count,
    output logic [CNT_W-1:0]   trunc_count
);

    typedef struct packed {
        logic [DATA_W-1:0]  data;
        logic               error;
        logic               sop;
        logic               eop;
        logic [EMPTY_W-1:0] empty;
    } beat_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        IN_PKT = 2'd1,
        DROP   = 2'd2
    } state_t;

    localparam logic [LVL_W-1:0] WR_LIMIT = LVL_W'(DEPTH - 2);

    state_t           state, state_d;
    beat_t            mem [DEPTH];
    beat_t            out_q;
    beat_t            wr_beat;
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [LVL_W-1:0] mem_cnt;
    logic             wr_en, rd_en, load_en;
    logic             drop_inc, trunc_inc;

    // Entries still in RAM: everything counted in the level except the beat on the output.
    assign mem_cnt = fifo_level - LVL_W'(out_valid);
    assign rd_en   = out_valid & out_ready;
    assign load_en = (mem_cnt != '0) & (~out_valid | out_ready);

    // Write-side admission: decisions use the level at the edge, no credit for same-cycle reads.
    always_comb begin
        state_d   = state;
        wr_en     = 1'b0;
        drop_inc  = 1'b0;
        trunc_inc = 1'b0;
        wr_beat   = '{data: in_data, error: in_error, sop: in_startofpacket,
                      eop: in_endofpacket, empty: in_empty};
        unique case (state)
            IDLE: begin
                if (in_valid && in_startofpacket) begin
                    if (fifo_level <= WR_LIMIT) begin
                        wr_en = 1'b1;
                        if (!in_endofpacket) state_d = IN_PKT;
                    end else begin
                        drop_inc = 1'b1;
                        if (!in_endofpacket) state_d = DROP;
                    end
                end
            end
            IN_PKT: begin
                if (in_valid) begin
                    wr_en = 1'b1;
                    if (in_endofpacket) begin
                        state_d = IDLE;
                    end else if (fifo_level > WR_LIMIT) begin
                        // Last free slot: close the packet here as an errored frame.
                        wr_beat.eop   = 1'b1;
                        wr_beat.error = 1'b1;
                        wr_beat.empty = '0;
                        trunc_inc     = 1'b1;
                        state_d       = DROP;
                    end
                end
            end
            DROP: begin
                if (in_valid && in_endofpacket) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset_n && wr_en) mem[wr_ptr] <= wr_beat;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state       <= IDLE;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            fifo_level  <= '0;
            out_valid   <= 1'b0;
            out_q       <= '0;
            drop_count  <= '0;
            trunc_count <= '0;
        end else begin
            state <= state_d;
            if (wr_en) wr_ptr <= wr_ptr + AW'(1);
            if (load_en) begin
                out_q  <= mem[rd_ptr];
                rd_ptr <= rd_ptr + AW'(1);
            end
            out_valid <= load_en | (out_valid & ~out_ready);
            unique case ({wr_en, rd_en})
                2'b10:   fifo_level <= fifo_level + LVL_W'(1);
                2'b01:   fifo_level <= fifo_level - LVL_W'(1);
                default: fifo_level <= fifo_level;
            endcase
            if (drop_inc && (drop_count != '1)) drop_count <= drop_count + CNT_W'(1);
            if (trunc_inc && (trunc_count != '1)) trunc_count <= trunc_count + CNT_W'(1);
        end
    end

    assign out_data          = out_q.data;
    assign out_error         = out_q.error;
    assign out_startofpacket = out_q.sop;
    assign out_endofpacket   = out_q.eop;
    assign out_empty         = out_q.empty;

endmodule

// File: tb/tb_eth_10g_rx_st_drop_fifo.sv
// Bench for eth_10g_rx_st_drop_fifo: directed scenarios plus randomized traffic,
// scored against a queue-based packet model of the admission and drain rules.
module tb_eth_10g_rx_st_drop_fifo;

    localparam int unsigned DATA_W  = 64;
    localparam int unsigned EMPTY_W = 3;
    localparam int unsigned DEPTH   = 8;
    localparam int unsigned CNT_W   = 4;
    localparam int unsigned LVL_W   = $clog2(DEPTH) + 1;
    localparam int          CMAX    = (1 << CNT_W) - 1;

    typedef struct packed {
        logic [DATA_W-1:0]  data;
        logic               error;
        logic               sop;
        logic               eop;
        logic [EMPTY_W-1:0] empty;
    } beat_t;

    logic               clk = 1'b0;
    logic               reset_n;
    logic               in_valid;
    logic [DATA_W-1:0]  in_data;
    logic               in_error;
    logic               in_startofpacket;
    logic               in_endofpacket;
    logic [EMPTY_W-1:0] in_empty;
    logic               out_valid;
    logic [DATA_W-1:0]  out_data;
    logic               out_error;
    logic               out_startofpacket;
    logic               out_endofpacket;
    logic [EMPTY_W-1:0] out_empty;
    logic               out_ready;
    logic [LVL_W-1:0]   fifo_level;
    logic [CNT_W-1:0]   drop_count;
    logic [CNT_W-1:0]   trunc_count;

    eth_10g_rx_st_drop_fifo #(
        .DATA_W(DATA_W), .EMPTY_W(EMPTY_W), .DEPTH(DEPTH), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .in_valid(in_valid), .in_data(in_data), .in_error(in_error),
        .in_startofpacket(in_startofpacket), .in_endofpacket(in_endofpacket),
        .in_empty(in_empty),
        .out_valid(out_valid), .out_data(out_data), .out_error(out_error),
        .out_startofpacket(out_startofpacket), .out_endofpacket(out_endofpacket),
        .out_empty(out_empty), .out_ready(out_ready),
        .fifo_level(fifo_level), .drop_count(drop_count), .trunc_count(trunc_count)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int dut_reads = 0;

    // Reference model: contents of the buffer as a queue, plus packet-tracking flags.
    beat_t exp_q[$];
    bit    m_valid, m_in_pkt, m_dropping;
    int    m_drops, m_truncs;

    task automatic model_clear();
        exp_q.delete();
        m_valid = 0; m_in_pkt = 0; m_dropping = 0;
        m_drops = 0; m_truncs = 0;
    endtask

    // One clock: drive inputs, score the output beat, advance the model, check state.
    task automatic step(input bit rst_a, input bit vld, input bit sop, input bit eop,
                        input logic [DATA_W-1:0] d, input bit err,
                        input logic [EMPTY_W-1:0] emp, input bit rdy);
        beat_t b, obs, head;
        int    s;
        bit    r, wr;
        reset_n = ~rst_a; in_valid = vld; in_startofpacket = sop; in_endofpacket = eop;
        in_data = d; in_error = err; in_empty = emp; out_ready = rdy;
        @(negedge clk);
        obs  = {out_data, out_error, out_startofpacket, out_endofpacket, out_empty};
        head = (exp_q.size() > 0) ? exp_q[0] : '0;
        if (m_valid) begin
            n_cmp++;
            if (exp_q.size() == 0 || obs !== head) begin
                n_bad++;
                $display("FAIL out_beat @%0t: got %h required %h", $time, obs, head);
            end
        end
        if (out_valid && rdy) dut_reads++;
        s  = exp_q.size();
        r  = m_valid && rdy && !rst_a;
        wr = 0;
        b  = '{data: d, error: err, sop: sop, eop: eop, empty: emp};
        if (rst_a) begin
            model_clear();
        end else begin
            if (vld) begin
                if (m_in_pkt) begin
                    wr = 1;
                    if (eop) m_in_pkt = 0;
                    else if (s > DEPTH - 2) begin
                        b.eop = 1; b.error = 1; b.empty = '0;
                        if (m_truncs < CMAX) m_truncs++;
                        m_in_pkt = 0; m_dropping = 1;
                    end
                end else if (m_dropping) begin
                    if (eop) m_dropping = 0;
                end else if (sop) begin
                    if (s <= DEPTH - 2) begin
                        wr = 1; m_in_pkt = !eop;
                    end else begin
                        if (m_drops < CMAX) m_drops++;
                        m_dropping = !eop;
                    end
                end
            end
            if (r) void'(exp_q.pop_front());
            m_valid = (s - int'(r)) > 0;
            if (wr) exp_q.push_back(b);
        end
        @(posedge clk);
        #1;
        n_cmp++;
        if (fifo_level !== LVL_W'(exp_q.size())) begin
            n_bad++;
            $display("FAIL fifo_level @%0t: got %0d required %0d", $time, fifo_level, exp_q.size());
        end
        n_cmp++;
        if (out_valid !== m_valid) begin
            n_bad++;
            $display("FAIL out_valid @%0t: got %0b required %0b", $time, out_valid, m_valid);
        end
        n_cmp++;
        if (drop_count !== CNT_W'(m_drops)) begin
            n_bad++;
            $display("FAIL drop_count @%0t: got %0d required %0d", $time, drop_count, m_drops);
        end
        n_cmp++;
        if (trunc_count !== CNT_W'(m_truncs)) begin
            n_bad++;
            $display("FAIL trunc_count @%0t: got %0d required %0d", $time, trunc_count, m_truncs);
        end
    endtask

    task automatic do_reset();
        step(1, 0, 0, 0, '0, 0, '0, 0);
    endtask

    task automatic idle(input bit rdy, input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, '0, 0, '0, rdy);
    endtask

    task automatic send(input bit sop, input bit eop, input logic [DATA_W-1:0] d,
                        input logic [EMPTY_W-1:0] emp, input bit rdy);
        step(0, 1, sop, eop, d, 0, emp, rdy);
    endtask

    // Packet of n beats with data base+i.
    task automatic send_pkt(input int n, input logic [DATA_W-1:0] base, input bit rdy);
        for (int i = 0; i < n; i++)
            send(i == 0, i == n - 1, base + DATA_W'(i), (i == n - 1) ? 3'd2 : 3'd0, rdy);
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++;
        if (out_valid !== 1'b0 || out_data !== '0 || out_endofpacket !== 1'b0 ||
            out_startofpacket !== 1'b0 || out_error !== 1'b0 || out_empty !== '0) begin
            n_bad++;
            $display("FAIL reset_outputs: got v=%0b d=%h required v=0 d=0", out_valid, out_data);
        end
    endtask

    task automatic test_basic();
        int r0;
        do_reset();
        r0 = dut_reads;
        send(1, 0, 64'h11, 3'd0, 1);
        send(0, 0, 64'h22, 3'd0, 1);
        send(0, 1, 64'h33, 3'd5, 1);
        idle(1, 3);
        n_cmp++;
        if (dut_reads - r0 !== 3) begin
            n_bad++;
            $display("FAIL basic_beats: got %0d required 3", dut_reads - r0);
        end
    endtask

    task automatic test_truncate();
        int r0;
        do_reset();
        send_pkt(10, 64'h100, 0);
        n_cmp++;
        if (trunc_count !== CNT_W'(1) || fifo_level !== LVL_W'(8)) begin
            n_bad++;
            $display("FAIL trunc_state: got trunc=%0d level=%0d required 1/8", trunc_count, fifo_level);
        end
        r0 = dut_reads;
        idle(1, 12);
        n_cmp++;
        if (dut_reads - r0 !== 8) begin
            n_bad++;
            $display("FAIL trunc_drain: got %0d required 8", dut_reads - r0);
        end
    endtask

    task automatic test_drop_whole();
        int r0;
        do_reset();
        send_pkt(7, 64'h200, 0);
        send_pkt(4, 64'h300, 0);
        n_cmp++;
        if (drop_count !== CNT_W'(1) || fifo_level !== LVL_W'(7)) begin
            n_bad++;
            $display("FAIL drop_state: got drop=%0d level=%0d required 1/7", drop_count, fifo_level);
        end
        idle(1, 10);
        r0 = dut_reads;
        send_pkt(3, 64'h400, 1);
        idle(1, 3);
        n_cmp++;
        if (dut_reads - r0 !== 3) begin
            n_bad++;
            $display("FAIL drop_next_pkt: got %0d required 3", dut_reads - r0);
        end
    endtask

    task automatic test_stray();
        do_reset();
        send(0, 0, 64'hAA, 3'd0, 0);
        idle(0, 2);
        n_cmp++;
        if (fifo_level !== '0 || out_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL stray_beat: got level=%0d valid=%0b required 0/0", fifo_level, out_valid);
        end
    endtask

    task automatic test_simultaneous();
        do_reset();
        send(1, 0, 64'h500, 3'd0, 0);
        for (int i = 1; i < 6; i++) send(0, 0, 64'h500 + DATA_W'(i), 3'd0, 0);
        send(0, 0, 64'h506, 3'd0, 1);
        n_cmp++;
        if (fifo_level !== LVL_W'(6)) begin
            n_bad++;
            $display("FAIL simul_level: got %0d required 6", fifo_level);
        end
        send(0, 1, 64'h507, 3'd1, 1);
        idle(1, 10);
    endtask

    task automatic test_reset_mid();
        int r0;
        do_reset();
        send_pkt(7, 64'h600, 0);
        send_pkt(4, 64'h650, 0);
        idle(1, 10);
        send(1, 0, 64'h700, 3'd0, 0);
        for (int i = 1; i < 4; i++) send(0, 0, 64'h700 + DATA_W'(i), 3'd0, 0);
        do_reset();
        n_cmp++;
        if (fifo_level !== '0 || out_valid !== 1'b0 || drop_count !== '0 || trunc_count !== '0) begin
            n_bad++;
            $display("FAIL reset_mid: got level=%0d valid=%0b drop=%0d required 0/0/0",
                     fifo_level, out_valid, drop_count);
        end
        send(0, 0, 64'h704, 3'd0, 1);
        send(0, 1, 64'h705, 3'd3, 1);
        r0 = dut_reads;
        send_pkt(2, 64'h800, 1);
        idle(1, 3);
        n_cmp++;
        if (dut_reads - r0 !== 2) begin
            n_bad++;
            $display("FAIL reset_next_pkt: got %0d required 2", dut_reads - r0);
        end
    endtask

    task automatic test_saturation();
        do_reset();
        send_pkt(7, 64'h900, 0);
        for (int i = 0; i < 20; i++) send(1, 1, 64'hA00 + DATA_W'(i), 3'd0, 0);
        n_cmp++;
        if (drop_count !== CNT_W'(CMAX)) begin
            n_bad++;
            $display("FAIL drop_saturate: got %0d required %0d", drop_count, CMAX);
        end
        idle(1, 10);
    endtask

    task automatic test_random();
        bit gen_in, sop, eop, vld, rdy;
        int rp;
        do_reset();
        gen_in = 0;
        for (int c = 0; c < 2400; c++) begin
            case ((c / 200) % 3)
                0: rp = 15;
                1: rp = 55;
                default: rp = 90;
            endcase
            vld = ($urandom_range(0, 99) < 75);
            sop = gen_in ? ($urandom_range(0, 99) < 3) : ($urandom_range(0, 99) < 92);
            eop = ($urandom_range(0, 99) < 25);
            rdy = ($urandom_range(0, 99) < rp);
            if (vld) begin
                if (sop) gen_in = 1;
                if (eop) gen_in = 0;
            end
            step(0, vld, sop, eop, {$urandom, $urandom}, $urandom_range(0, 1) == 1,
                 EMPTY_W'($urandom_range(0, 7)), rdy);
        end
        idle(1, 12);
        n_cmp++;
        if (fifo_level !== '0 || exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL random_drain: got level=%0d required 0", fifo_level);
        end
    endtask

    initial begin
        reset_n = 0; in_valid = 0; in_data = '0; in_error = 0;
        in_startofpacket = 0; in_endofpacket = 0; in_empty = '0; out_ready = 0;
        model_clear();
        test_reset();
        test_basic();
        test_truncate();
        test_drop_whole();
        test_stray();
        test_simultaneous();
        test_reset_mid();
        test_saturation();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/eth_10g_rx_st_drop_fifo.md
Name: eth_10g_rx_st_drop_fifo

Overview:
- Buffering stage directly downstream of the RX frame-status timing adapter in the 10G MAC receive path.
- The adapter's upstream cannot be backpressured, so this block accepts one Avalon-ST beat per valid cycle without fail. It buffers beats in a packet-aware FIFO and presents them to the client with ready/valid flow control.
- On overflow it truncates or drops whole packets so the output stream always stays well-framed (SOP … EOP).

Parameters:
- DATA_W, 64, data bus width.
- EMPTY_W, 3, empty-field width.
- DEPTH, 64, FIFO entries. Power of 2, ≥4.
- CNT_W, 32, statistics counter width.

Ports:
- clk  in  1  clock.
- reset_n  in  1  synchronous active-low reset.
- in_valid  in  1  beat present. No ready is returned upstream.
- in_data  in  DATA_W  payload.
- in_error  in  1  frame error flag.
- in_startofpacket  in  1  SOP.
- in_endofpacket  in  1  EOP.
- in_empty  in  EMPTY_W  empty bytes, valid on EOP.
- out_valid  out  1  beat available.
- out_data  out  DATA_W  payload.
- out_error  out  1  error flag.
- out_startofpacket  out  1  SOP.
- out_endofpacket  out  1  EOP.
- out_empty  out  EMPTY_W  empty bytes.
- out_ready  in  1  downstream accept.
- fifo_level  out  log2(DEPTH)+1  stored entries.
- drop_count  out  CNT_W  whole packets dropped. Saturating.
- trunc_count  out  CNT_W  packets truncated. Saturating.

Behaviour:
- Clocking and reset
  - Single clock. reset_n is sampled on the clk rising edge.
  - Reset clears FIFO pointers, fifo_level, drop_count, trunc_count and state (→IDLE).
  - Reset forces out_valid=0. out_data, out_error, out_startofpacket, out_endofpacket and out_empty reset to 0.
  - A reset asserted mid-packet abandons that packet. Beats after reset without SOP are discarded.
- Write-side FSM: IDLE, IN_PKT, DROP. L = fifo_level at the clock edge; a same-cycle read gives no credit to the write decision.
  - IDLE, valid & SOP:
    - If L ≤ DEPTH-2: write the beat. Go to IN_PKT, or stay in IDLE if EOP is also set.
    - Else: discard the beat, drop_count+1. Go to DROP, or stay in IDLE if EOP is also set.
  - IDLE, valid & !SOP: stray beat, discarded. No counter change.
  - IN_PKT, valid:
    - If EOP: write normally, go to IDLE.
    - Else if L ≤ DEPTH-2: write normally.
    - Else (L = DEPTH-1): write the beat with eop=1, error=1, empty=0. trunc_count+1. Go to DROP.
  - IN_PKT, SOP seen again: written unchanged. This is an upstream protocol violation and is not repaired.
  - DROP: discard all beats. A valid EOP returns the FSM to IDLE.
  - Level can never exceed DEPTH, so a write is never lost to a full FIFO.
- Read side
  - Show-ahead FIFO with a registered output stage.
  - A beat written at edge N is visible on out_* with out_valid=1 after edge N+1 when the FIFO was empty (latency 1).
  - A beat leaves when out_valid & out_ready.
  - out_* remains stable while out_valid & !out_ready.
- Level: fifo_level += write − read, updated each edge. A simultaneous write and read leaves the level unchanged.
- Counters: saturate at all-ones. No wrap.

Test Plan (DEPTH=8):
1. out_ready=1; 3-beat packet (SOP d=0x11, d=0x22, EOP d=0x33 empty=5) → the same 3 beats appear at the output, each one cycle after input. Empty=5 on the last beat. Both counters stay 0.
2. out_ready=0; 10-beat packet → beats 0–6 stored normally. Beat 7 is stored with eop=1, error=1, empty=0. Beats 8–9 are discarded. trunc_count=1, fifo_level=8. Releasing ready drains exactly 8 beats.
3. fifo_level=7, out_ready=0; new SOP 4-beat packet → nothing written, drop_count=1, level stays 7. After draining, the next packet is accepted intact.
4. Valid beat without SOP in IDLE (d=0xAA) → not written; level and counters unchanged.
5. fifo_level=6, IN_PKT, out_ready=1 with a simultaneous non-EOP write → level stays 6. Output order is preserved.
6. reset_n=0 for one cycle mid-packet with level=4 → level=0, out_valid=0, counters=0. Subsequent non-SOP beats are discarded. The next SOP packet passes.
